// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard receiver: filters the lines, frames bytes, tracks held keys and queues press/release events.
// Optional build macro PS2_PARITY_CHECK_EN rejects frames whose odd parity is wrong.
module ps2_key_matrix #(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned NUM_KEYS       = 21,
    parameter logic [NUM_KEYS*8-1:0] KEYMAP =
        168'h3A_31_32_2A_21_22_1A_3B_33_34_2B_23_1B_1C_3C_35_2C_2D_24_1D_15,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_dat,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [4:0]          evt_key,
    output logic                evt_release,
    output logic                frame_err,
    output logic                overflow
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EW = 6;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state, state_n;
    logic [1:0]        clk_sync, dat_sync;
    logic [DW-1:0]     div_cnt;
    logic              tick_c;
    logic [FILTER_LEN-1:0] clk_flt, dat_flt;
    logic              clk_f, dat_f, clk_f_q, fall_c;
    logic [7:0]        shreg;
    logic [2:0]        bit_cnt;
    logic              par_bit;
    logic [TW-1:0]     to_cnt;
    logic              timeout_c, stop_ok_c, byte_ok_c, frame_err_c;
    logic              brk, ext, brk_n, ext_n;
    logic [NUM_KEYS-1:0] ks_n;
    logic              push_q, push_n;
    logic [EW-1:0]     push_data_q, push_data_n;
    logic              hit_c;
    logic [4:0]        idx_c;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, wr_n, rd_n;
    logic              full_c, pop_c, push_do_c;
    logic [EW-1:0]     head, head_n;

    // Two-flop synchronisers and sample-tick divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            div_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            div_cnt  <= tick_c ? '0 : div_cnt + DW'(1);
        end
    end

    assign tick_c = (div_cnt == DW'(CLK_DIV - 1));

    // Majority-free glitch filter: a line moves only when every sample agrees
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_flt <= '1;
            dat_flt <= '1;
            clk_f   <= 1'b1;
            dat_f   <= 1'b1;
            clk_f_q <= 1'b1;
        end else begin
            if (tick_c) begin
                clk_flt <= {clk_flt[FILTER_LEN-2:0], clk_sync[1]};
                dat_flt <= {dat_flt[FILTER_LEN-2:0], dat_sync[1]};
            end
            if (&clk_flt)            clk_f <= 1'b1;
            else if (clk_flt == '0)  clk_f <= 1'b0;
            if (&dat_flt)            dat_f <= 1'b1;
            else if (dat_flt == '0)  dat_f <= 1'b0;
            clk_f_q <= clk_f;
        end
    end

    assign fall_c = clk_f_q & ~clk_f;

`ifdef PS2_PARITY_CHECK_EN
    assign stop_ok_c = dat_f & (^{shreg, par_bit});
`else
    logic unused_par_c;
    assign unused_par_c = par_bit;
    assign stop_ok_c    = dat_f;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n     = state;
        frame_err_c = 1'b0;
        byte_ok_c   = 1'b0;
        timeout_c   = (state != IDLE) && !fall_c && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
        if (timeout_c) begin
            state_n     = IDLE;
            frame_err_c = 1'b1;
        end else if (fall_c) begin
            case (state)
                IDLE:    if (!dat_f) state_n = DATA;
                DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
                PARITY:  state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    if (stop_ok_c) byte_ok_c   = 1'b1;
                    else           frame_err_c = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Frame datapath and inter-edge watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            to_cnt <= (state == IDLE || fall_c || timeout_c) ? '0 : to_cnt + TW'(1);
            if (fall_c) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {dat_f, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= dat_f;
                    default: ;
                endcase
            end
        end
    end

    // Byte decode: prefix flags, lowest-index keymap match, key tracking
    always_comb begin
        brk_n       = brk;
        ext_n       = ext;
        ks_n        = key_state;
        push_n      = 1'b0;
        push_data_n = '0;
        hit_c       = 1'b0;
        idx_c       = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (!hit_c && KEYMAP[8*i +: 8] == shreg) begin
                hit_c = 1'b1;
                idx_c = 5'(i);
            end
        end
        if (byte_ok_c) begin
            if (shreg == 8'hF0)      brk_n = 1'b1;
            else if (shreg == 8'hE0) ext_n = 1'b1;
            else begin
                brk_n = 1'b0;
                ext_n = 1'b0;
                if (!ext && hit_c) begin
                    if (!brk && !key_state[idx_c]) begin
                        ks_n[idx_c] = 1'b1;
                        push_n      = 1'b1;
                        push_data_n = {idx_c, 1'b0};
                    end else if (brk && key_state[idx_c]) begin
                        ks_n[idx_c] = 1'b0;
                        push_n      = 1'b1;
                        push_data_n = {idx_c, 1'b1};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk         <= 1'b0;
            ext         <= 1'b0;
            key_state   <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err   <= 1'b0;
        end else begin
            brk         <= brk_n;
            ext         <= ext_n;
            key_state   <= ks_n;
            push_q      <= push_n;
            push_data_q <= push_data_n;
            frame_err   <= frame_err_c;
        end
    end

    // Event FIFO with a registered head word
    assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_c     = evt_valid & evt_ready;
    assign push_do_c = push_q & (~full_c | pop_c);
    assign wr_n      = wr_ptr + (AW+1)'(push_do_c);
    assign rd_n      = rd_ptr + (AW+1)'(pop_c);
    assign head_n    = (push_do_c && wr_ptr[AW-1:0] == rd_n[AW-1:0]) ? push_data_q
                                                                     : mem[rd_n[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_do_c) mem[wr_ptr[AW-1:0]] <= push_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_valid <= 1'b0;
            head      <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_n;
            rd_ptr    <= rd_n;
            evt_valid <= (wr_n != rd_n);
            head      <= head_n;
            overflow  <= overflow | (push_q & full_c & ~pop_c);
        end
    end

    assign evt_key     = head[EW-1:1];
    assign evt_release = head[0];

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: drives PS/2 frames and checks key tracking, events and errors.
module tb_ps2_key_matrix;

    localparam int unsigned H  = 60;
    localparam int unsigned TO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        evt_ready = 1'b0;
    logic [20:0] key_state;
    logic        evt_valid, evt_release, frame_err, overflow;
    logic [4:0]  evt_key;

    int total = 0;
    int bad = 0;
    logic [5:0] evq[$];
    int err_cnt = 0;
    int unsigned cyc = 0;
    int unsigned ks_cyc = 0;
    int unsigned ev_cyc = 0;
    logic [20:0] ks_prev = '0;
    logic ev_prev = 1'b0;

    ps2_key_matrix #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .key_state(key_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_key(evt_key), .evt_release(evt_release),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rst && evt_valid && evt_ready) evq.push_back({evt_key, evt_release});
        if (rst && frame_err) err_cnt++;
    end

    always @(negedge clk) begin
        if (key_state !== ks_prev) begin
            ks_cyc  = cyc;
            ks_prev = key_state;
        end
        if (evt_valid && !ev_prev) ev_cyc = cyc;
        ev_prev = evt_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic badpar);
        return {1'b1, (~^b) ^ badpar, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic badpar = 1'b0);
        send_bits(frame(b, badpar), 11);
        wait_cyc(H);
    endtask

    task automatic apply_reset();
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rst = 1'b0;
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wait_cyc(3);
        total++; if (key_state !== 21'h0) begin bad++; $display("FAIL reset_keys: got %0h want 0", key_state); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %0b want 0", frame_err); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
        rst = 1'b1;
        wait_cyc(50);
        total++; if (evt_valid !== 1'b0 || key_state !== 21'h0) begin bad++; $display("FAIL idle_after_reset: valid=%0b keys=%0h want 0/0", evt_valid, key_state); end
    endtask

    task automatic test_make_break();
        int qb;
        evt_ready = 1'b1;
        qb = evq.size();
        send_byte(8'h1C);
        total++; if (key_state !== 21'h80) begin bad++; $display("FAIL make_keys: got %0h want 80", key_state); end
        total++; if (evq.size() != qb + 1 || evq[qb] !== {5'd7, 1'b0}) begin bad++; $display("FAIL make_evt: n=%0d ev=%0h want n=%0d ev=0e", evq.size() - qb, evq[qb], 1); end
        send_byte(8'hF0);
        total++; if (evq.size() != qb + 1) begin bad++; $display("FAIL f0_no_evt: n=%0d want 1", evq.size() - qb); end
        send_byte(8'h1C);
        total++; if (key_state !== 21'h0) begin bad++; $display("FAIL break_keys: got %0h want 0", key_state); end
        total++; if (evq.size() != qb + 2 || evq[qb+1] !== {5'd7, 1'b1}) begin bad++; $display("FAIL break_evt: n=%0d ev=%0h want n=2 ev=0f", evq.size() - qb, evq[qb+1]); end
    endtask

    task automatic test_queue();
        int qb;
        evt_ready = 1'b0;
        qb = evq.size();
        send_byte(8'h1C);
        total++; if (evt_valid !== 1'b1 || evt_key !== 5'd7 || evt_release !== 1'b0) begin bad++; $display("FAIL q_head1: v=%0b k=%0d r=%0b want 1/7/0", evt_valid, evt_key, evt_release); end
        total++; if (ev_cyc - ks_cyc != 1) begin bad++; $display("FAIL q_latency: got %0d want 1", ev_cyc - ks_cyc); end
        send_byte(8'h1B);
        total++; if (evt_key !== 5'd7 || evt_release !== 1'b0) begin bad++; $display("FAIL q_stable2: k=%0d r=%0b want 7/0", evt_key, evt_release); end
        send_byte(8'h23);
        total++; if (evt_valid !== 1'b1 || evt_key !== 5'd7) begin bad++; $display("FAIL q_stable3: v=%0b k=%0d want 1/7", evt_valid, evt_key); end
        total++; if (key_state !== 21'h380) begin bad++; $display("FAIL q_keys: got %0h want 380", key_state); end
        evt_ready = 1'b1;
        wait_cyc(10);
        total++; if (evq.size() != qb + 3) begin bad++; $display("FAIL q_count: got %0d want 3", evq.size() - qb); end
        total++; if (evq[qb] !== 6'h0e || evq[qb+1] !== 6'h10 || evq[qb+2] !== 6'h12) begin bad++; $display("FAIL q_order: got %0h %0h %0h want e 10 12", evq[qb], evq[qb+1], evq[qb+2]); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL q_drained: got %0b want 0", evt_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h1C, 8'h1B};
        int qb;
        apply_reset();
        evt_ready = 1'b0;
        qb = evq.size();
        for (int i = 0; i < 9; i++) begin
            send_byte(codes[i]);
            if (i == 7) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %0b want 0", overflow); end
            end
        end
        total++; if (key_state !== 21'h1FF) begin bad++; $display("FAIL ovf_keys: got %0h want 1ff", key_state); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        total++; if (evt_valid !== 1'b1 || evt_key !== 5'd0) begin bad++; $display("FAIL ovf_head: v=%0b k=%0d want 1/0", evt_valid, evt_key); end
        evt_ready = 1'b1;
        wait_cyc(20);
        total++; if (evq.size() != qb + 8) begin bad++; $display("FAIL ovf_count: got %0d want 8", evq.size() - qb); end
        total++; if (evq[qb] !== 6'h00 || evq[qb+7] !== 6'h0e) begin bad++; $display("FAIL ovf_order: got %0h %0h want 0 e", evq[qb], evq[qb+7]); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_parity();
        int qb, e0;
        apply_reset();
        evt_ready = 1'b1;
        qb = evq.size();
        e0 = err_cnt;
        send_byte(8'h15, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        total++; if (err_cnt != e0 + 1) begin bad++; $display("FAIL par_err: got %0d want 1", err_cnt - e0); end
        total++; if (evq.size() != qb || key_state !== 21'h0) begin bad++; $display("FAIL par_discard: n=%0d keys=%0h want 0/0", evq.size() - qb, key_state); end
`else
        total++; if (err_cnt != e0) begin bad++; $display("FAIL par_err: got %0d want 0", err_cnt - e0); end
        total++; if (evq.size() != qb + 1 || evq[qb] !== 6'h00 || key_state !== 21'h1) begin bad++; $display("FAIL par_accept: n=%0d ev=%0h keys=%0h want 1/0/1", evq.size() - qb, evq[qb], key_state); end
`endif
    endtask

    task automatic test_timeout();
        int qb, e0;
        apply_reset();
        evt_ready = 1'b1;
        qb = evq.size();
        e0 = err_cnt;
        send_bits(frame(8'h1D, 1'b0), 4);
        wait_cyc(TO + 100);
        total++; if (err_cnt != e0 + 1) begin bad++; $display("FAIL to_err: got %0d want 1", err_cnt - e0); end
        total++; if (evt_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL to_quiet: v=%0b fe=%0b want 0/0", evt_valid, frame_err); end
        send_byte(8'h1D);
        total++; if (evq.size() != qb + 1 || evq[qb] !== 6'h02) begin bad++; $display("FAIL to_recover: n=%0d ev=%0h want 1/2", evq.size() - qb, evq[qb]); end
        total++; if (err_cnt != e0 + 1) begin bad++; $display("FAIL to_no_extra_err: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_ext();
        int qb;
        apply_reset();
        evt_ready = 1'b1;
        qb = evq.size();
        send_byte(8'hE0);
        send_byte(8'h1C);
        total++; if (evq.size() != qb || key_state !== 21'h0) begin bad++; $display("FAIL ext_ignored: n=%0d keys=%0h want 0/0", evq.size() - qb, key_state); end
        send_byte(8'h1D);
        send_byte(8'h1D);
        send_byte(8'h1D);
        total++; if (evq.size() != qb + 1 || evq[qb] !== 6'h02) begin bad++; $display("FAIL typematic: n=%0d ev=%0h want 1/2", evq.size() - qb, evq[qb]); end
        total++; if (key_state !== 21'h2) begin bad++; $display("FAIL typematic_keys: got %0h want 2", key_state); end
    endtask

    task automatic test_midframe_reset();
        int qb, e0;
        evt_ready = 1'b1;
        send_bits(frame(8'h1C, 1'b0), 5);
        apply_reset();
        qb = evq.size();
        e0 = err_cnt;
        wait_cyc(H);
        send_byte(8'h1B);
        total++; if (key_state !== 21'h100) begin bad++; $display("FAIL mid_keys: got %0h want 100", key_state); end
        total++; if (evq.size() != qb + 1 || evq[qb] !== 6'h10 || err_cnt != e0) begin bad++; $display("FAIL mid_evt: n=%0d ev=%0h err=%0d want 1/10/0", evq.size() - qb, evq[qb], err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_queue();
        test_overflow();
        test_parity();
        test_timeout();
        test_ext();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
